// File: rtl/dcc_pkg.sv
// Shared types and constants for the DCC track H-bridge driver.
// Gate vectors are ordered {ha, la, hb, lb}.
package dcc_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEAD  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_RETRY = 3'd3,
    ST_LOCK  = 3'd4
  } state_t;

  localparam int DEF_DEAD_CYCLES  = 8;
  localparam int DEF_FAULT_FILT   = 16;
  localparam int DEF_RETRY_CYCLES = 500000;
  localparam int DEF_MAX_RETRIES  = 3;

  localparam logic [3:0] A_POS   = 4'b1001;
  localparam logic [3:0] B_POS   = 4'b0110;
  localparam logic [3:0] ALL_OFF = 4'b0000;

endpackage

// File: rtl/dcc_hbridge_driver_if.sv
// Control/status bundle between the track generator side
// and the H-bridge driver.
interface dcc_hbridge_driver_if;

  logic       enable;
  logic       track_in;
  logic       oc_fault;
  logic       fault_clear;
  logic       gate_ha;
  logic       gate_la;
  logic       gate_hb;
  logic       gate_lb;
  logic       driving;
  logic       fault_latched;
  logic [1:0] retry_count;

  modport master (
    output enable, track_in, oc_fault, fault_clear,
    input  gate_ha, gate_la, gate_hb, gate_lb,
    input  driving, fault_latched, retry_count
  );

  modport slave (
    input  enable, track_in, oc_fault, fault_clear,
    output gate_ha, gate_la, gate_hb, gate_lb,
    output driving, fault_latched, retry_count
  );

endinterface

// File: rtl/dcc_fault_filter.sv
// Over-current comparator synchroniser and debounce.
// Emits a one-cycle fault_evt after FAULT_FILT synced-high cycles.
module dcc_fault_filter #(
  parameter int FAULT_FILT = 16
) (
  input  logic pclk,
  input  logic reset,
  input  logic oc_fault,
  input  logic filt_en,
  output logic fault_evt
);

  localparam int FW = $clog2(FAULT_FILT + 1);

  logic          s1;
  logic          s2;
  logic [FW-1:0] cnt;

  always_ff @(posedge pclk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      fault_evt <= 1'b0;
    end else begin
      s1        <= oc_fault;
      s2        <= s1;
      fault_evt <= 1'b0;
      if (!filt_en || !s2) begin
        cnt <= '0;
      end else if (cnt == FW'(FAULT_FILT - 1)) begin
        cnt       <= '0;
        fault_evt <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcc_hbridge_driver.sv
// H-bridge gate driver: dead time, fault shutdown with
// timed retry, and lockout after repeated faults.
import dcc_pkg::*;

module dcc_hbridge_driver #(
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int FAULT_FILT   = DEF_FAULT_FILT,
  parameter int RETRY_CYCLES = DEF_RETRY_CYCLES,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input logic                 pclk,
  input logic                 reset,
  dcc_hbridge_driver_if.slave bus
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int RW = $clog2(RETRY_CYCLES + 1);

  state_t        state_q;
  state_t        state_d;
  state_t        fault_st;
  logic          p_q;
  logic          p_d;
  logic [3:0]    gates_q;
  logic [3:0]    gate_d;
  logic          driving_q;
  logic          latched_q;
  logic [1:0]    rc_q;
  logic [DW-1:0] dead_cnt;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] hlth_cnt;
  logic          fault_evt;
  logic          filt_en;
  logic          dead_done;
  logic          retry_done;
  logic          in_drive;
  logic          hlth_done;
  logic          fault_hit;

  assign filt_en = (state_q == ST_DEAD) ||
                   (state_q == ST_DRIVE);

  dcc_fault_filter #(
    .FAULT_FILT (FAULT_FILT)
  ) u_filt (
    .pclk      (pclk),
    .reset     (reset),
    .oc_fault  (bus.oc_fault),
    .filt_en   (filt_en),
    .fault_evt (fault_evt)
  );

  assign dead_done  = dead_cnt == DW'(DEAD_CYCLES - 1);
  assign retry_done = retry_cnt == RW'(RETRY_CYCLES - 1);
  assign fault_st   = ((int'(rc_q) + 1) > MAX_RETRIES) ?
                      ST_LOCK : ST_RETRY;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF: begin
        if (bus.enable) state_d = ST_DEAD;
      end
      ST_DEAD: begin
        if (!bus.enable)     state_d = ST_OFF;
        else if (fault_evt)  state_d = fault_st;
        else if (dead_done)  state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!bus.enable)     state_d = ST_OFF;
        else if (fault_evt)  state_d = fault_st;
        else if (bus.track_in != p_q)
          state_d = ST_DEAD;
      end
      ST_RETRY: begin
        if (!bus.enable)     state_d = ST_OFF;
        else if (retry_done) state_d = ST_DEAD;
      end
      ST_LOCK: begin
        if (bus.fault_clear) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    p_d = p_q;
    if (state_q == ST_DEAD && state_d == ST_DRIVE)
      p_d = bus.track_in;
    gate_d = ALL_OFF;
    if (state_d == ST_DRIVE)
      gate_d = p_d ? A_POS : B_POS;
  end

  assign in_drive  = (state_q == ST_DRIVE) &&
                     (state_d == ST_DRIVE);
  assign hlth_done = in_drive &&
                     (hlth_cnt == RW'(RETRY_CYCLES - 1));
  assign fault_hit = filt_en &&
                     ((state_d == ST_RETRY) ||
                      (state_d == ST_LOCK));

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      p_q       <= 1'b0;
      gates_q   <= ALL_OFF;
      driving_q <= 1'b0;
      latched_q <= 1'b0;
      rc_q      <= '0;
      dead_cnt  <= '0;
      retry_cnt <= '0;
      hlth_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      gates_q   <= gate_d;
      driving_q <= state_d == ST_DRIVE;
      latched_q <= state_d == ST_LOCK;
      dead_cnt  <= (state_q == ST_DEAD &&
                    state_d == ST_DEAD) ?
                   dead_cnt + 1'b1 : '0;
      retry_cnt <= (state_q == ST_RETRY &&
                    state_d == ST_RETRY) ?
                   retry_cnt + 1'b1 : '0;
      // Polarity dead time pauses the healthy timer.
      if (in_drive)
        hlth_cnt <= hlth_done ? '0 : hlth_cnt + 1'b1;
      else if (state_d != ST_DEAD && state_d != ST_DRIVE)
        hlth_cnt <= '0;
      if (fault_hit)
        rc_q <= (rc_q == 2'd3) ? rc_q : rc_q + 1'b1;
      else if (state_q == ST_LOCK && state_d == ST_OFF)
        rc_q <= '0;
      else if (hlth_done)
        rc_q <= '0;
    end
  end

  assign bus.gate_ha       = gates_q[3];
  assign bus.gate_la       = gates_q[2];
  assign bus.gate_hb       = gates_q[1];
  assign bus.gate_lb       = gates_q[0];
  assign bus.driving       = driving_q;
  assign bus.fault_latched = latched_q;
  assign bus.retry_count   = rc_q;

endmodule
